// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux.
// Optional handover statistics counter enabled by defining MUX2_ARB_STATS_EN.
module mux2_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk_311,
    input  logic       rst_n_311,
    input  logic       req0_311,
    input  logic       req1_311,
    output logic       grant0_311,
    output logic       grant1_311,
    output logic       sel_311,
    output logic       busy_311
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [7:0] switch_cnt_311
`endif
);

    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last;
    logic               last_nxt;
    logic               sel_nxt;
    logic               hold_end_c;

    // State, tenure counter and registered outputs
    always_ff @(posedge clk_311) begin
        if (!rst_n_311) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            grant0_311 <= 1'b0;
            grant1_311 <= 1'b0;
            sel_311    <= 1'b0;
            busy_311   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            grant0_311 <= (state_nxt == G0);
            grant1_311 <= (state_nxt == G1);
            sel_311    <= sel_nxt;
            busy_311   <= (state_nxt != IDLE);
        end
    end

    assign hold_end_c = (cnt == CNT_W'(HOLD_MAX - 1));

    // Next-state: release beats preempt, both resolve to a direct switch
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        sel_nxt   = sel_311;

        unique case (state)
            IDLE: begin
                if (req0_311 && req1_311) begin
                    state_nxt = last ? G0 : G1;
                end else if (req0_311) begin
                    state_nxt = G0;
                end else if (req1_311) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!req0_311 && req1_311) begin
                    state_nxt = G1;
                end else if (!req0_311) begin
                    state_nxt = IDLE;
                end else if (req1_311 && hold_end_c) begin
                    state_nxt = G1;
                end else begin
                    cnt_nxt = hold_end_c ? '0 : cnt + CNT_W'(1);
                end
            end
            G1: begin
                if (!req1_311 && req0_311) begin
                    state_nxt = G0;
                end else if (!req1_311) begin
                    state_nxt = IDLE;
                end else if (req0_311 && hold_end_c) begin
                    state_nxt = G0;
                end else begin
                    cnt_nxt = hold_end_c ? '0 : cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Fresh grant: restart tenure, remember owner, steer the mux
        if ((state_nxt != IDLE) && (state_nxt != state)) begin
            cnt_nxt  = '0;
            last_nxt = (state_nxt == G1);
            sel_nxt  = (state_nxt == G1);
        end
    end

`ifdef MUX2_ARB_STATS_EN
    logic handover_c;

    assign handover_c = (state != IDLE) && (state_nxt != IDLE) && (state_nxt != state);

    // Saturating count of direct G0<->G1 handovers
    always_ff @(posedge clk_311) begin
        if (!rst_n_311) begin
            switch_cnt_311 <= 8'd0;
        end else if (handover_c && (switch_cnt_311 != 8'hFF)) begin
            switch_cnt_311 <= switch_cnt_311 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: HOLD_MAX=4 and HOLD_MAX=1 instances
// checked against a tenure-based reference model under directed and random stimulus.
module tb_mux2_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic req0;
    logic req1;
    logic g0_a, g1_a, sel_a, busy_a;
    logic g0_b, g1_b, sel_b, busy_b;
`ifdef MUX2_ARB_STATS_EN
    logic [7:0] sw_a, sw_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner (-1 idle), tenure since grant, last owner, select, switches
    int m_owner[2];
    int m_ten[2];
    int m_last[2];
    int m_sel[2];
    int m_sw[2];
    int hold[2] = '{4, 1};

    mux2_arbiter #(.HOLD_MAX(4)) dut_a (
        .clk_311        (clk),
        .rst_n_311      (rst_n),
        .req0_311       (req0),
        .req1_311       (req1),
        .grant0_311     (g0_a),
        .grant1_311     (g1_a),
        .sel_311        (sel_a),
        .busy_311       (busy_a)
`ifdef MUX2_ARB_STATS_EN
        ,
        .switch_cnt_311 (sw_a)
`endif
    );

    mux2_arbiter #(.HOLD_MAX(1)) dut_b (
        .clk_311        (clk),
        .rst_n_311      (rst_n),
        .req0_311       (req0),
        .req1_311       (req1),
        .grant0_311     (g0_b),
        .grant1_311     (g1_b),
        .sel_311        (sel_b),
        .busy_311       (busy_b)
`ifdef MUX2_ARB_STATS_EN
        ,
        .switch_cnt_311 (sw_b)
`endif
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic give_to(input int k, input int who, input logic is_switch);
        m_owner[k] = who;
        m_ten[k]   = 0;
        m_last[k]  = who;
        m_sel[k]   = who;
        if (is_switch && m_sw[k] < 255) m_sw[k]++;
    endtask

    // Predicts the state after the next rising edge from the current inputs
    task automatic model_step(input int k);
        int mine, other;
        if (!rst_n) begin
            m_owner[k] = -1; m_ten[k] = 0; m_last[k] = 1; m_sel[k] = 0; m_sw[k] = 0;
        end else if (m_owner[k] < 0) begin
            if (req0 && req1)  give_to(k, (m_last[k] == 0) ? 1 : 0, 1'b0);
            else if (req0)     give_to(k, 0, 1'b0);
            else if (req1)     give_to(k, 1, 1'b0);
        end else begin
            mine  = (m_owner[k] == 1) ? int'(req1) : int'(req0);
            other = (m_owner[k] == 1) ? int'(req0) : int'(req1);
            if (mine == 0 && other != 0)
                give_to(k, 1 - m_owner[k], 1'b1);
            else if (mine == 0)
                m_owner[k] = -1;
            else if (other != 0 && (m_ten[k] % hold[k]) == hold[k] - 1)
                give_to(k, 1 - m_owner[k], 1'b1);
            else
                m_ten[k]++;
        end
    endtask

    task automatic check_all();
        check("a_grant0", g0_a, m_owner[0] == 0);
        check("a_grant1", g1_a, m_owner[0] == 1);
        check("a_sel",    sel_a, m_sel[0] == 1);
        check("a_busy",   busy_a, m_owner[0] >= 0);
        check("a_excl",   g0_a & g1_a, 1'b0);
        check("b_grant0", g0_b, m_owner[1] == 0);
        check("b_grant1", g1_b, m_owner[1] == 1);
        check("b_sel",    sel_b, m_sel[1] == 1);
        check("b_busy",   busy_b, m_owner[1] >= 0);
`ifdef MUX2_ARB_STATS_EN
        check8("a_switch_cnt", sw_a, 8'(m_sw[0]));
        check8("b_switch_cnt", sw_b, 8'(m_sw[1]));
`endif
    endtask

    task automatic step(input logic r, input logic a, input logic b);
        rst_n = r;
        req0  = a;
        req1  = b;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic r, a, b;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_ten[k] = 0; m_last[k] = 1; m_sel[k] = 0; m_sw[k] = 0;
        end
        #1;

        // Reset held with both requesting
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("rst_grant0", g0_a, 1'b0);
        check("rst_grant1", g1_a, 1'b0);
        check("rst_busy",   busy_a, 1'b0);
        check("rst_sel",    sel_a, 1'b0);

        // Fairness from release: HOLD 4 gives 0000 1111 ..., HOLD 1 alternates
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b1, 1'b1);
            if (j == 0) check("release_grant0", g0_a, 1'b1);
            check("fair_sel_h4", sel_a, ((j / 4) % 2) == 1);
            check("alt_sel_h1",  sel_b, (j % 2) == 1);
        end

        // Single requester holds with no preemption, then releases
        step(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b0, 1'b1);
            check("single_grant1", g1_a, 1'b1);
            check("single_sel",    sel_a, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        check("single_idle_busy", busy_a, 1'b0);
        check("single_idle_sel",  sel_a, 1'b1);

        // Release handover with no bubble
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_handover_g0", g0_a, 1'b1);
`ifdef MUX2_ARB_STATS_EN
        begin
            logic [7:0] before;
            before = sw_a;
            step(1'b1, 1'b0, 1'b1);
            check8("handover_stat", sw_a, before + 8'd1);
        end
`else
        step(1'b1, 1'b0, 1'b1);
`endif
        check("handover_g1",   g1_a, 1'b1);
        check("handover_g0",   g0_a, 1'b0);
        check("handover_busy", busy_a, 1'b1);

        // HOLD_MAX=1: six cycles of dual request give five switches
        step(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b1, 1'b1);
            check("h1_toggle", sel_b, (j % 2) == 1);
        end
`ifdef MUX2_ARB_STATS_EN
        check8("h1_switches", sw_b, 8'd5);
`endif

        // Reset mid-grant in G1 at tenure 2
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("midrst_g1",   g1_a, 1'b0);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_sel",  sel_a, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("midrst_first_g0", g0_a, 1'b1);

        // Random traffic with occasional reset
        for (int j = 0; j < 3000; j++) begin
            r = ($urandom_range(0, 63) != 0);
            a = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 2) != 0);
            step(r, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
